instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//  Instruction prefetch buffer directly downstream of the PC/fetch stage.
//  Takes the fetch PC, issues it to a synchronous instruction memory, and queues
//  {pc, instr} pairs in a small FIFO for the decode stage (valid/ready handshake).
//  Back-pressures fetch via fetch_stall and discards everything on a taken-branch flush.
// PARAMETERS
//  DEPTH  4  queue entries; power of two, >= 2
//  AW     2  pointer width = log2(DEPTH)
// PORTS
//  Clock        in   1   rising-edge clock
//  Reset        in   1   asynchronous, active-low reset
//  fetch_addr   in   32  PC from fetch stage
//  fetch_valid  in   1   fetch_addr is a valid request this cycle
//  fetch_stall  out  1   1 = fetch must hold PC; request not accepted
//  flush        in   1   taken branch (B & Z); discard queue and in-flight read
//  imem_addr    out  32  instruction memory address (= fetch_addr, combinational)
//  imem_rdata   in   32  memory data, valid the cycle after imem_addr
//  dec_valid    out  1   head entry valid
//  dec_ready    in   1   decode consumes head entry
//  dec_instr    out  32  head instruction
//  dec_pc       out  32  PC of head instruction
//  q_count      out  AW+1  occupied entries (excludes in-flight read)
// BEHAVIOUR
//  - Reset (async, Reset==0): rd/wr ptrs=0, q_count=0, pending=0, pending_pc=0;
//    dec_valid=0, dec_instr=0, dec_pc=0, fetch_stall=0. All storage is clocked on
//    posedge Clock; reset releases synchronously at the next edge.
//  - fetch_stall = (q_count + pending) >= DEPTH (combinational; reserves slot for in-flight read).
//  - Accept: acc = fetch_valid & ~fetch_stall & ~flush. On acc at cycle t: pending<=1,
//    pending_pc<=fetch_addr. At t+1 (pending==1) {pending_pc, imem_rdata} is written to
//    queue at wr_ptr; pending clears unless a new acc occurs that cycle. Back-to-back
//    accepts give one push per cycle. Latency fetch_addr -> dec_valid = 2 cycles when empty.
//  - Pop: dec_valid & dec_ready advances rd_ptr. Simultaneous push+pop: q_count unchanged.
//  - dec_valid = (q_count != 0); dec_instr/dec_pc = head entry when valid, else 0.
//  - Pointers wrap modulo DEPTH; q_count never exceeds DEPTH (guaranteed by stall rule).
//  - Pop when empty and push when full cannot occur; if dec_ready=1 while empty: no-op.
//  - Flush (highest priority): next edge q_count=0, ptrs=0, pending=0; any pop, push or
//    accept in the flush cycle is ignored; the memory response of the flush cycle and of
//    a read issued before it is dropped. fetch_stall=0 the cycle after flush.
//  - Flush asserted on consecutive cycles: queue stays empty, nothing accepted.
//  - Reset mid-operation: all entries and pending read lost; no output glitch other than
//    immediate dec_valid=0.
// CONFIGURATION
//  IFQ_PERF_EN defined: adds outputs flush_cnt[15:0] (counts cycles with flush=1) and
//    stall_cnt[15:0] (counts cycles with fetch_valid & fetch_stall); both saturate at
//    16'hFFFF, reset to 0, unaffected by flush.
//  IFQ_PERF_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 Reset: Reset=0 mid-run -> dec_valid=0, q_count=0, fetch_stall=0, dec_instr=0 at once.
//  2 Stream: fetch_addr 0,4,8 valid, dec_ready=1, imem returns A,B,C -> dec (0,A) 2 cycles
//    after first request, then (4,B),(8,C) on consecutive cycles; q_count<=1.
//  3 Fill: DEPTH=4, dec_ready=0, 6 requests -> exactly 4 accepted, fetch_stall=1 after 4th
//    accept, q_count=4; one pop -> stall drops, 5th request accepted, q_count back to 4.
//  4 Flush: q_count=3 plus pending read, flush=1 one cycle -> q_count=0, dec_valid=0 next
//    cycle, in-flight data never appears; next request at 0x40 appears as dec_pc=0x40.
//  5 Wrap: 10 push/pop pairs with dec_ready toggling -> order preserved across pointer wrap.
//  6 IFQ_PERF_EN: 3 flush cycles, 5 stalled requests -> flush_cnt=3, stall_cnt=5.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: issues the fetch PC to a synchronous imem and buffers {pc, instr}
// pairs for decode. Define IFQ_PERF_EN to add the flush_cnt/stall_cnt performance counters.
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic [31:0]   fetch_addr,
    input  logic          fetch_valid,
    output logic          fetch_stall,
    input  logic          flush,
    output logic [31:0]   imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [31:0]   dec_instr,
    output logic [31:0]   dec_pc,
    output logic [AW:0]   q_count
`ifdef IFQ_PERF_EN
    ,
    output logic [15:0]   flush_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pending;
    logic [31:0]   pending_pc;

    logic [AW:0]   occupancy;
    logic          acc;
    logic          push;
    logic          pop;

    // Handshakes: fetch transfers when fetch_valid & ~fetch_stall & ~flush; decode transfers
    // when dec_valid & dec_ready. Both sides sample on the rising edge; flush overrides both.
    assign imem_addr   = fetch_addr;
    assign occupancy   = q_count + {{AW{1'b0}}, pending};
    assign fetch_stall = (occupancy >= DEPTH_C);
    assign acc         = fetch_valid & ~fetch_stall & ~flush;
    assign push        = pending & ~flush;
    assign dec_valid   = (q_count != '0);
    assign pop         = dec_valid & dec_ready & ~flush;

    assign dec_instr   = dec_valid ? instr_q[rd_ptr] : 32'h0;
    assign dec_pc      = dec_valid ? pc_q[rd_ptr]    : 32'h0;

    // The pending slot is counted in occupancy so the read in flight always has room to land.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            pending    <= 1'b0;
            pending_pc <= 32'h0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            pending    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
            pending <= acc;
            if (acc) pending_pc <= fetch_addr;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= 32'h0;
                instr_q[i] <= 32'h0;
            end
        end else if (push) begin
            pc_q[wr_ptr]    <= pending_pc;
            instr_q[wr_ptr] <= imem_rdata;
        end
    end

`ifdef IFQ_PERF_EN
    // Counters saturate instead of wrapping so a long run never reports a small value.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            flush_cnt <= 16'h0;
            stall_cnt <= 16'h0;
        end else begin
            if (flush && (flush_cnt != 16'hFFFF))
                flush_cnt <= flush_cnt + 16'h1;
            if (fetch_valid && fetch_stall && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'h1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue: scoreboard queue of expected {pc, instr} pairs
// checked by a decode-side monitor, plus direct checks of counts, stall and flush behaviour.
module tb_instr_fetch_queue;

    logic        Clock;
    logic        Reset;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic        fetch_stall;
    logic        flush;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [2:0]  q_count;
`ifdef IFQ_PERF_EN
    logic [15:0] flush_cnt;
    logic [15:0] stall_cnt;
`endif

    logic [63:0] exp_q[$];
    int          checks;
    int          errors;

    instr_fetch_queue #(.DEPTH(4), .AW(2)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_stall (fetch_stall),
        .flush       (flush),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .q_count     (q_count)
`ifdef IFQ_PERF_EN
        ,
        .flush_cnt   (flush_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    // Clock and reset-free memory model: word at address a is 32'hA000_0000 | a, one cycle later.
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) imem_rdata <= 32'hA000_0000 | imem_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_valid = 1'b1;
        fetch_addr  = a;
    endtask

    task automatic idle();
        fetch_valid = 1'b0;
    endtask

    task automatic expect_pair(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    // Monitor: every decode transfer must match the oldest expected pair.
    always @(negedge Clock) begin
        logic [63:0] e;
        if (Reset && !flush && dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dec_unexpected: got pc=%h instr=%h required no transfer", dec_pc, dec_instr);
            end else begin
                e = exp_q.pop_front();
                check("dec_out", {dec_pc, dec_instr}, e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        Reset       = 1'b0;
        fetch_addr  = 32'h0;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        dec_ready   = 1'b0;

        // Reset state
        step();
        step();
        check("rst_dec_valid", 64'(dec_valid), 64'h0);
        check("rst_q_count", 64'(q_count), 64'h0);
        check("rst_stall", 64'(fetch_stall), 64'h0);
        check("rst_dec_instr", 64'(dec_instr), 64'h0);
        check("rst_dec_pc", 64'(dec_pc), 64'h0);
        Reset = 1'b1;

        // Reset mid-operation discards queued entries immediately
        fetch(32'h500); step();
        fetch(32'h504); step();
        idle();         step();
        check("midrst_pre_count", 64'(q_count), 64'h2);
        #3 Reset = 1'b0;
        #1;
        check("midrst_dec_valid", 64'(dec_valid), 64'h0);
        check("midrst_q_count", 64'(q_count), 64'h0);
        check("midrst_stall", 64'(fetch_stall), 64'h0);
        check("midrst_dec_instr", 64'(dec_instr), 64'h0);
        #2 Reset = 1'b1;
        step();

        // Stream: 2-cycle latency, then one pair per cycle
        dec_ready = 1'b1;
        expect_pair(32'h0, 32'hA000_0000);
        expect_pair(32'h4, 32'hA000_0004);
        expect_pair(32'h8, 32'hA000_0008);
        fetch(32'h0); step();
        check("stream_lat1_valid", 64'(dec_valid), 64'h0);
        fetch(32'h4); step();
        check("stream_lat2_valid", 64'(dec_valid), 64'h1);
        check("stream_first_pc", 64'(dec_pc), 64'h0);
        check("stream_first_instr", 64'(dec_instr), 64'hA000_0000);
        fetch(32'h8); step();
        check("stream_count_a", 64'(q_count), 64'h1);
        idle(); step();
        check("stream_count_b", 64'(q_count), 64'h1);
        step();
        check("stream_count_c", 64'(q_count), 64'h0);

        // Fill: four accepts, then stall until a pop frees a slot
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch(32'h100 + 32'(4 * i));
            expect_pair(32'h100 + 32'(4 * i), 32'hA000_0100 + 32'(4 * i));
            step();
        end
        check("fill_stall_after4", 64'(fetch_stall), 64'h1);
        check("fill_count_3", 64'(q_count), 64'h3);
        fetch(32'h110);
        expect_pair(32'h110, 32'hA000_0110);
        step();
        check("fill_count_4", 64'(q_count), 64'h4);
        check("fill_stall_full", 64'(fetch_stall), 64'h1);
        step();
        check("fill_count_hold", 64'(q_count), 64'h4);
        dec_ready = 1'b1; step();
        dec_ready = 1'b0;
        check("fill_pop_count", 64'(q_count), 64'h3);
        check("fill_pop_stall", 64'(fetch_stall), 64'h0);
        step();
        check("fill_5th_count", 64'(q_count), 64'h3);
        check("fill_5th_stall", 64'(fetch_stall), 64'h1);
        idle(); step();
        check("fill_refull", 64'(q_count), 64'h4);
        dec_ready = 1'b1;
        repeat (4) step();
        check("fill_drained", 64'(q_count), 64'h0);

        // Flush with three queued entries and a read in flight, held for two cycles
        dec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            fetch(32'h200 + 32'(4 * i));
            step();
        end
        check("flush_pre_count", 64'(q_count), 64'h3);
        flush = 1'b1;
        dec_ready = 1'b1;
        fetch(32'h210);
        step();
        check("flush_count", 64'(q_count), 64'h0);
        check("flush_dec_valid", 64'(dec_valid), 64'h0);
        check("flush_stall", 64'(fetch_stall), 64'h0);
        step();
        flush = 1'b0;
        idle();
        check("flush2_count", 64'(q_count), 64'h0);
        step();
        check("flush_no_leak_a", 64'(dec_valid), 64'h0);
        step();
        check("flush_no_leak_b", 64'(dec_valid), 64'h0);
        expect_pair(32'h40, 32'hA000_0040);
        fetch(32'h40); step();
        idle(); step();
        check("flush_next_valid", 64'(dec_valid), 64'h1);
        check("flush_next_pc", 64'(dec_pc), 64'h40);
        step();
        check("flush_next_drained", 64'(q_count), 64'h0);

        // Wrap: ten pairs with dec_ready toggling, order must survive pointer wrap
        for (int i = 0; i < 10; i++) begin
            expect_pair(32'h300 + 32'(4 * i), 32'hA000_0300 + 32'(4 * i));
            fetch(32'h300 + 32'(4 * i));
            dec_ready = (i % 2) == 1;
            step();
            idle();
            dec_ready = (i % 2) == 0;
            step();
        end
        dec_ready = 1'b1;
        repeat (3) step();
        check("wrap_drained", 64'(q_count), 64'h0);
        dec_ready = 1'b0;

        // Counters: fresh reset, five stalled request cycles, then three flush cycles
        Reset = 1'b0;
        #2 Reset = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            fetch(32'h600 + 32'(4 * i));
            step();
        end
        fetch(32'h610);
        repeat (5) step();
        idle();
        check("perf_full_count", 64'(q_count), 64'h4);
        check("perf_full_stall", 64'(fetch_stall), 64'h1);
`ifdef IFQ_PERF_EN
        check("perf_stall_cnt", 64'(stall_cnt), 64'h5);
        check("perf_flush_cnt0", 64'(flush_cnt), 64'h0);
`endif
        flush = 1'b1;
        repeat (3) step();
        flush = 1'b0;
        check("perf_flush_count", 64'(q_count), 64'h0);
        check("perf_flush_stall", 64'(fetch_stall), 64'h0);
`ifdef IFQ_PERF_EN
        check("perf_flush_cnt", 64'(flush_cnt), 64'h3);
        check("perf_stall_kept", 64'(stall_cnt), 64'h5);
`endif
        step();

        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
